// File: rtl/verif_dmem_if.sv
// Core-side data-memory bus: load/store strobes, byte address, store data with
// lane enables, and the load data / stall returned by the memory.
interface verif_dmem_if;
  logic        we;
  logic        re;
  logic [31:0] a;
  logic [31:0] wd;
  logic [3:0]  byteEnable;
  logic [31:0] rd;
  logic        stall;

  modport master (output we, re, a, wd, byteEnable, input rd, stall);
  modport slave  (input we, re, a, wd, byteEnable, output rd, stall);
endinterface

// File: rtl/verif_dmem.sv
// Verification data memory: byte-lane RAM with configurable load latency plus a
// memory-mapped test-status / cycle-counter / store-counter region.
module verif_dmem #(
  parameter int unsigned DEPTH_WORDS  = 64,
  parameter int unsigned READ_LATENCY = 0,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_FF00,
  parameter logic [31:0] BAD_READ     = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  verif_dmem_if.slave       bus,
  output logic              done,
  output logic              pass,
  output logic              err,
  output logic [31:0]       cycleCount
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  LAT = READ_LATENCY[1:0];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return merged;
  endfunction

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [1:0]    rd_cnt_q, rd_cnt_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          err_q, err_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   stores_q, stores_d;

  logic          ram_hit_s, mmio_hit_s, miss_s;
  logic [AW-1:0] ram_idx_s;
  logic          stall_s, load_done_s, store_fire_s, ram_we_s;
  logic [31:0]   reg_rd_s, rd_data_s;
  logic          unused_s;

  assign unused_s = ^bus.a[1:0];

  // Address decode, stall handshake and load data selection.
  always_comb begin
    ram_hit_s  = (bus.a[31:AW+2] == {(30-AW){1'b0}});
    mmio_hit_s = (bus.a[31:8] == MMIO_BASE[31:8]);
    miss_s     = !ram_hit_s && !mmio_hit_s;
    ram_idx_s  = bus.a[AW+1:2];

    // The count never exceeds LAT, so "count != LAT" is "count < LAT".
    stall_s      = !reset && bus.re && (rd_cnt_q != LAT);
    load_done_s  = !reset && bus.re && !stall_s;
    // A load held across stall cycles must not repeat its store.
    store_fire_s = !reset && bus.we && (!bus.re || (rd_cnt_q == 2'd0));
    ram_we_s     = store_fire_s && ram_hit_s;

    case (bus.a[7:2])
      6'd0:    reg_rd_s = {30'd0, pass_q, done_q};
      6'd1:    reg_rd_s = cycle_q;
      6'd2:    reg_rd_s = stores_q;
      default: reg_rd_s = 32'd0;
    endcase

    if (ram_hit_s) begin
      rd_data_s = mem_q[ram_idx_s];
    end else if (mmio_hit_s) begin
      rd_data_s = reg_rd_s;
    end else begin
      rd_data_s = BAD_READ;
    end

    if (load_done_s) begin
      bus.rd = rd_data_s;
    end else begin
      bus.rd = 32'd0;
    end
    bus.stall = stall_s;
  end

  // Next-state for the latency counter, status, error flag and counters.
  always_comb begin
    if (!bus.re || (rd_cnt_q == LAT)) begin
      rd_cnt_d = 2'd0;
    end else begin
      rd_cnt_d = rd_cnt_q + 2'd1;
    end

    done_d = done_q;
    pass_d = pass_q;
    if (store_fire_s && mmio_hit_s && (bus.a[7:2] == 6'd0) && !done_q) begin
      done_d = 1'b1;
      pass_d = (bus.wd == 32'd1);
    end else begin
      done_d = done_q;
    end

    err_d = err_q | (miss_s & (store_fire_s | load_done_s));

    if (store_fire_s && (stores_q != 32'hFFFF_FFFF)) begin
      stores_d = stores_q + 32'd1;
    end else begin
      stores_d = stores_q;
    end

    // Freeze on the same edge that raises done so the count reads the finish cycle.
    if (!done_d && (cycle_q != 32'hFFFF_FFFF)) begin
      cycle_d = cycle_q + 32'd1;
    end else begin
      cycle_d = cycle_q;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 2'd0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 1'b0;
      cycle_q  <= 32'd0;
      stores_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
    end
  end

  // RAM array: contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[ram_idx_s] <= merge_lanes(mem_q[ram_idx_s], bus.wd, bus.byteEnable);
    end
  end

  assign done       = done_q;
  assign pass       = pass_q;
  assign err        = err_q;
  assign cycleCount = cycle_q;

endmodule
